// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, CHANNELS compare outputs, double-buffered duty/period/mode.
// Latency: out is registered one clk after the counter; boundary pulses in the clk after the reload edge.
// Backpressure: none; the counter advances only on ena & step, and duty writes are always accepted.
// Optional: define PWM_MULTI_POLARITY_EN to add a per-channel output polarity input.
module pwm_multi #(
    parameter int N        = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                step,
    input  logic [N-1:0]        period,
    input  logic                center,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [N-1:0]        wr_duty,
`ifdef PWM_MULTI_POLARITY_EN
    input  logic [CHANNELS-1:0] polarity,
`endif
    output logic [CHANNELS-1:0] out,
    output logic                boundary
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [N-1:0] counter;
    logic [N-1:0] cnt_nxt;
    dir_t         dir;
    dir_t         dir_nxt;
    logic         wrap;

    logic [N-1:0] active_period;
    logic         active_center;
    logic [N-1:0] active_duty [CHANNELS];
    logic [N-1:0] shadow_duty [CHANNELS];

    logic [CHANNELS-1:0] cmp;
    logic [CHANNELS-1:0] out_nxt;
    logic [CHANNELS-1:0] out_rst;
    logic                wr_ok;

    // Channel indices past CHANNELS-1 exist when CHANNELS is not a power of two; drop those writes.
    assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(CHANNELS));

`ifdef PWM_MULTI_POLARITY_EN
    assign out_rst = polarity;
`else
    assign out_rst = '0;
`endif

    // Counter/direction next state and period-wrap detection.
    // Center mode walks 0..P..1 and wraps on the step that would land back on 0,
    // so each period starts at counter 0 going up and lasts 2P steps (1 step when P = 0).
    always_comb begin
        cnt_nxt = counter;
        dir_nxt = dir;
        wrap    = 1'b0;
        if (ena && step) begin
            if (!active_center) begin
                if (counter == active_period) begin
                    wrap = 1'b1;
                end else begin
                    cnt_nxt = counter + N'(1);
                end
            end else if (dir == DIR_UP) begin
                if (counter == active_period) begin
                    // At the top: turning around from 0 or 1 lands on 0, which is the wrap point.
                    if (counter <= N'(1)) begin
                        wrap = 1'b1;
                    end else begin
                        cnt_nxt = counter - N'(1);
                        dir_nxt = DIR_DOWN;
                    end
                end else begin
                    cnt_nxt = counter + N'(1);
                end
            end else begin
                if (counter <= N'(1)) begin
                    wrap = 1'b1;
                end else begin
                    cnt_nxt = counter - N'(1);
                end
            end
            if (wrap) begin
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
            end
        end
    end

    // Counter and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            dir     <= DIR_UP;
        end else begin
            counter <= cnt_nxt;
            dir     <= dir_nxt;
        end
    end

    // Active period/mode/duties reload only at the wrap so a running pulse is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_period <= '1;
            active_center <= 1'b0;
            boundary      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                active_duty[i] <= '0;
            end
        end else begin
            boundary <= wrap;
            if (wrap) begin
                active_period <= period;
                active_center <= center;
                for (int i = 0; i < CHANNELS; i++) begin
                    active_duty[i] <= shadow_duty[i];
                end
            end
        end
    end

    // Shadow duty writes; a write on the reload edge is seen by the next reload, not this one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_duty[i] <= '0;
            end
        end else if (wr_ok) begin
            shadow_duty[wr_ch] <= wr_duty;
        end
    end

    // Per-channel compare, gated by ena, then optional polarity inversion.
    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp[i] = (counter < active_duty[i]);
        end
        out_nxt = ena ? cmp : '0;
`ifdef PWM_MULTI_POLARITY_EN
        out_nxt = out_nxt ^ polarity;
`endif
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= out_rst;
        end else begin
            out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus random traffic against a phase-based reference model.
// The model tracks position within the period and derives the counter value from it arithmetically.
// Outputs are compared #1 after every rising edge.
module tb_pwm_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       step = 1'b0;
    logic [7:0] period = 8'd0;
    logic       center = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = 2'd0;
    logic [7:0] wr_duty = 8'd0;
    logic [3:0] out;
    logic       boundary;
`ifdef PWM_MULTI_POLARITY_EN
    logic [3:0] polarity = 4'b0000;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_multi #(.N(8), .CHANNELS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .step     (step),
        .period   (period),
        .center   (center),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_duty  (wr_duty),
`ifdef PWM_MULTI_POLARITY_EN
        .polarity (polarity),
`endif
        .out      (out),
        .boundary (boundary)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: position within the current period.
    int         m_pos;
    int         m_ap;
    int         m_ac;
    int         m_ad [4];
    int         m_sd [4];
    logic [3:0] m_out;
    logic       m_bnd;

    function automatic int plen();
        if (m_ac != 0) return (m_ap == 0) ? 1 : 2 * m_ap;
        return m_ap + 1;
    endfunction

    function automatic int cnt_of();
        if (m_ac != 0 && m_pos > m_ap) return 2 * m_ap - m_pos;
        return m_pos;
    endfunction

    function automatic logic wrap_next();
        return ena && step && (m_pos + 1 >= plen());
    endfunction

    task automatic model_step();
        if (rst) begin
            m_pos = 0; m_ap = 255; m_ac = 0;
            for (int i = 0; i < 4; i++) begin m_ad[i] = 0; m_sd[i] = 0; end
            m_out = 4'b0000;
`ifdef PWM_MULTI_POLARITY_EN
            m_out = polarity;
`endif
            m_bnd = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) m_out[i] = ena && (cnt_of() < m_ad[i]);
`ifdef PWM_MULTI_POLARITY_EN
        m_out = m_out ^ polarity;
`endif
        m_bnd = 1'b0;
        if (ena && step) begin
            if (m_pos + 1 >= plen()) begin
                m_bnd = 1'b1;
                m_ap = int'(period);
                m_ac = int'(center);
                for (int i = 0; i < 4; i++) m_ad[i] = m_sd[i];
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (wr_en) m_sd[wr_ch] = int'(wr_duty);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("boundary", 32'(boundary), 32'(m_bnd));
    endtask

    task automatic write(input int ch, input int d);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = 8'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    int hi [4];
    int nb;

    // Count high cycles per channel and boundary pulses over a window.
    task automatic count_window(input int len);
        for (int i = 0; i < 4; i++) hi[i] = 0;
        nb = 0;
        for (int c = 0; c < len; c++) begin
            cyc();
            for (int i = 0; i < 4; i++) if (out[i]) hi[i]++;
            if (boundary) nb++;
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_bnd", 32'(boundary), 32'h0);
        rst = 1'b0;

        // Edge-mode duty sweep, P = 9
        period = 8'd9; center = 1'b0;
        write(0, 0); write(1, 3); write(2, 9); write(3, 10);
        ena = 1'b1; step = 1'b1;
        repeat (300) cyc();
        count_window(10);
        chk("edge_hi0", 32'(hi[0]), 32'd0);
        chk("edge_hi1", 32'(hi[1]), 32'd3);
        chk("edge_hi2", 32'(hi[2]), 32'd9);
        chk("edge_hi3", 32'(hi[3]), 32'd10);
        chk("edge_bnd", 32'(nb), 32'd1);

        // Double buffering: active ch0 = 2, mid-period write of 5
        write(0, 2);
        repeat (12) cyc();
        repeat (3) cyc();
        write(0, 5);
        repeat (30) cyc();
        // Write coincident with the reload edge
        begin
            int guard = 0;
            while (!wrap_next() && guard < 600) begin cyc(); guard++; end
            chk("sync_found", 32'(guard < 600), 32'd1);
            write(0, 7);
            repeat (25) cyc();
        end

        // Period change 9 -> 4 mid-period
        repeat (4) cyc();
        period = 8'd4;
        repeat (30) cyc();
        count_window(5);
        chk("p4_bnd", 32'(nb), 32'd1);
        chk("p4_hi3", 32'(hi[3]), 32'd5);

        // Center mode, P = 4, ch0 duty 2
        center = 1'b1;
        write(0, 2);
        repeat (30) cyc();
        count_window(8);
        chk("ctr_hi0", 32'(hi[0]), 32'd3);
        chk("ctr_bnd", 32'(nb), 32'd1);
        count_window(8);
        chk("ctr_hi0_rep", 32'(hi[0]), 32'd3);

        // ena/step gating: step every 4th clk, ena dropped for 7 clks
        center = 1'b0; period = 8'd9;
        for (int c = 0; c < 120; c++) begin
            step = (c % 4 == 0);
            ena  = !(c >= 50 && c < 57);
            cyc();
            if (c >= 51 && c < 57) chk("ena_low_out", 32'(out), 32'h0);
        end
        ena = 1'b1; step = 1'b1;

        // Reset mid-period with pending writes
        write(1, 200);
        rst = 1'b1;
`ifdef PWM_MULTI_POLARITY_EN
        polarity = 4'b0101;
`endif
        cyc();
        rst = 1'b0; ena = 1'b0;
        repeat (3) cyc();
`ifdef PWM_MULTI_POLARITY_EN
        chk("pol_ena_low", 32'(out), 32'h5);
`else
        chk("rst_mid_out", 32'(out), 32'h0);
`endif
        ena = 1'b1;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            ena     = ($urandom_range(0, 9) != 0);
            step    = ($urandom_range(0, 1) == 1);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_duty = 8'($urandom_range(0, 14));
            if ($urandom_range(0, 49) == 0) period = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 79) == 0) center = ~center;
`ifdef PWM_MULTI_POLARITY_EN
            if ($urandom_range(0, 99) == 0) polarity = 4'($urandom_range(0, 15));
`endif
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
